// File: rtl/up_packet_transceiver.sv
// Byte-serial uP link engine: synchronises the uP handshake pins, collects a command packet,
// dispatches it as one parallel command, then returns the data/status reply byte by byte.
module up_packet_transceiver #(
  parameter int NOS_WRITE_BYTES = 6,
  parameter int NOS_READ_BYTES  = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int REPLY_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        async_uP_start,
  input  logic        async_uP_handshake_1,
  input  logic        async_uP_RW,
  input  logic [7:0]  uP_data_in,
  output logic [7:0]  uP_data_out,
  output logic        uP_data_oe,
  output logic        uP_handshake_2,
  output logic        uP_ack,
  output logic        cmd_valid,
  output logic [7:0]  cmd,
  output logic [7:0]  reg_address,
  output logic [31:0] reg_data,
  input  logic        reply_valid,
  input  logic [31:0] reply_data,
  input  logic [31:0] reply_status,
  output logic        busy
);

  localparam int IDX_W = $clog2(NOS_READ_BYTES);
  localparam logic [IDX_W-1:0] LAST_WR = IDX_W'(NOS_WRITE_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_RD = IDX_W'(NOS_READ_BYTES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(REPLY_TIMEOUT - 1);
  localparam logic [31:0] TIMEOUT_STATUS = 32'h8000_0001;

  typedef enum logic [2:0] {
    IDLE, RX_WAIT_HI, RX_WAIT_LO, DISPATCH, WAIT_REPLY, TX_WAIT_HI, TX_WAIT_LO, DONE
  } state_t;

  logic [SYNC_STAGES-1:0] start_sync_q, h1_sync_q, rw_sync_q;
  logic                   start_prev_q;
  logic                   start_s, h1_s, rw_s, start_rise;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             oe_q, oe_d;
  logic             hs2_q, hs2_d;
  logic             ack_q, ack_d;
  logic             cv_q, cv_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic [63:0]      tx_buf_q, tx_buf_d;
  logic [7:0]       rx_bytes_q [NOS_WRITE_BYTES];
  logic             rx_we;

  function automatic logic [7:0] tx_byte(input logic [63:0] buf_in, input logic [IDX_W-1:0] i);
    return buf_in[{i, 3'b000} +: 8];
  endfunction

  assign start_s    = start_sync_q[SYNC_STAGES-1];
  assign h1_s       = h1_sync_q[SYNC_STAGES-1];
  assign rw_s       = rw_sync_q[SYNC_STAGES-1];
  assign start_rise = start_s & ~start_prev_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    oe_d       = oe_q;
    hs2_d      = hs2_q;
    ack_d      = ack_q;
    cv_d       = 1'b0;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tx_buf_d   = tx_buf_q;
    rx_we      = 1'b0;
    // A start edge restarts reception from any state, abandoning whatever was in flight.
    if (start_rise) begin
      state_d = RX_WAIT_HI;
      idx_d   = '0;
      hs2_d   = 1'b0;
      oe_d    = 1'b0;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        RX_WAIT_HI: begin
          if (h1_s && rw_s) begin
            rx_we   = 1'b1;
            hs2_d   = 1'b1;
            state_d = RX_WAIT_LO;
          end
        end
        RX_WAIT_LO: begin
          if (!h1_s) begin
            hs2_d = 1'b0;
            if (idx_q == LAST_WR) begin
              state_d = DISPATCH;
              cv_d    = 1'b1;
              cmd_d   = rx_bytes_q[0];
              addr_d  = rx_bytes_q[1];
              wdata_d = {rx_bytes_q[5], rx_bytes_q[4], rx_bytes_q[3], rx_bytes_q[2]};
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = RX_WAIT_HI;
            end
          end
        end
        DISPATCH: begin
          cnt_d   = '0;
          state_d = WAIT_REPLY;
        end
        WAIT_REPLY: begin
          // A reply landing on the timeout cycle takes precedence over the timeout.
          if (reply_valid || cnt_q == TIMEOUT_LAST) begin
            tx_buf_d   = reply_valid ? {reply_status, reply_data} : {TIMEOUT_STATUS, 32'h0};
            idx_d      = '0;
            data_out_d = tx_buf_d[7:0];
            oe_d       = 1'b1;
            hs2_d      = 1'b1;
            state_d    = TX_WAIT_HI;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        TX_WAIT_HI: begin
          if (h1_s) begin
            hs2_d   = 1'b0;
            state_d = TX_WAIT_LO;
          end
        end
        TX_WAIT_LO: begin
          if (!h1_s) begin
            if (idx_q == LAST_RD) begin
              oe_d    = 1'b0;
              ack_d   = 1'b1;
              state_d = DONE;
            end else begin
              idx_d      = idx_q + IDX_W'(1);
              data_out_d = tx_byte(tx_buf_q, idx_d);
              hs2_d      = 1'b1;
              state_d    = TX_WAIT_HI;
            end
          end
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // Control, synchronisers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sync_q <= '0;
      h1_sync_q    <= '0;
      rw_sync_q    <= '0;
      start_prev_q <= 1'b0;
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      oe_q         <= 1'b0;
      hs2_q        <= 1'b0;
      ack_q        <= 1'b0;
      cv_q         <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], async_uP_start};
      h1_sync_q    <= {h1_sync_q[SYNC_STAGES-2:0], async_uP_handshake_1};
      rw_sync_q    <= {rw_sync_q[SYNC_STAGES-2:0], async_uP_RW};
      start_prev_q <= start_s;
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      oe_q         <= oe_d;
      hs2_q        <= hs2_d;
      ack_q        <= ack_d;
      cv_q         <= cv_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
    end
  end

  // Packet buffers carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    tx_buf_q <= tx_buf_d;
    if (rx_we) rx_bytes_q[idx_q] <= uP_data_in;
  end

  assign uP_data_out    = data_out_q;
  assign uP_data_oe     = oe_q;
  assign uP_handshake_2 = hs2_q;
  assign uP_ack         = ack_q;
  assign cmd_valid      = cv_q;
  assign cmd            = cmd_q;
  assign reg_address    = addr_q;
  assign reg_data       = wdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_up_packet_transceiver.sv
// Self-checking bench for up_packet_transceiver: acts as the uP and the register bank,
// comparing against table constants and a transaction-level packet model.
module tb_up_packet_transceiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        async_uP_start, async_uP_handshake_1, async_uP_RW;
  logic [7:0]  uP_data_in;
  logic [7:0]  uP_data_out;
  logic        uP_data_oe, uP_handshake_2, uP_ack, cmd_valid, busy;
  logic [7:0]  cmd, reg_address;
  logic [31:0] reg_data;
  logic        reply_valid;
  logic [31:0] reply_data, reply_status;

  up_packet_transceiver dut (
    .clk(clk), .reset(reset),
    .async_uP_start(async_uP_start), .async_uP_handshake_1(async_uP_handshake_1),
    .async_uP_RW(async_uP_RW), .uP_data_in(uP_data_in),
    .uP_data_out(uP_data_out), .uP_data_oe(uP_data_oe), .uP_handshake_2(uP_handshake_2),
    .uP_ack(uP_ack), .cmd_valid(cmd_valid), .cmd(cmd), .reg_address(reg_address),
    .reg_data(reg_data), .reply_valid(reply_valid), .reply_data(reply_data),
    .reply_status(reply_status), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cv_count = 0;

  always @(posedge clk) if (cmd_valid === 1'b1) cv_count++;

  typedef struct {
    logic [47:0] wr;        // byte 0 in bits [7:0]
    bit          reply_en;
    logic [31:0] rdata;
    logic [31:0] rstatus;
    logic [7:0]  e_cmd;
    logic [7:0]  e_addr;
    logic [31:0] e_data;
    logic [63:0] e_rd;      // read byte i in bits [8i+7:8i]
  } vec_t;

  vec_t tbl [3];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return uP_handshake_2;
      1: return cmd_valid;
      default: return uP_ack;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int budget, input string name,
                          output int waited);
    waited = 0;
    while (sig(sel) !== val && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (sig(sel) !== val) begin
      miscompares++;
      $display("FAIL %s: got no event within %0d cycles, expected level %0b", name, budget, val);
    end
  endtask

  task automatic pulse_start();
    async_uP_start = 1'b1;
    tick(4);
    async_uP_start = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    int w;
    uP_data_in = b;
    async_uP_RW = 1'b1;
    async_uP_handshake_1 = 1'b1;
    wait_for(0, 1'b1, 20, "rx_hs2_rise", w);
    async_uP_handshake_1 = 1'b0;
    wait_for(0, 1'b0, 20, "rx_hs2_fall", w);
    async_uP_RW = 1'b0;
  endtask

  task automatic drive_reply(input logic [31:0] d, input logic [31:0] s);
    reply_valid = 1'b1;
    reply_data = d;
    reply_status = s;
    tick(1);
    reply_valid = 1'b0;
  endtask

  // Transaction-level model: the reply packet is data then status, each LSB first.
  function automatic logic [63:0] model_rd(input bit reply_en, input logic [31:0] d,
                                           input logic [31:0] s);
    return reply_en ? {s, d} : {32'h8000_0001, 32'h0000_0000};
  endfunction

  task automatic run_txn(input vec_t v, input int delay);
    int w;
    int cv0;
    cv0 = cv_count;
    pulse_start();
    for (int i = 0; i < 6; i++) write_byte(v.wr[8*i +: 8]);
    wait_for(1, 1'b1, 20, "cmd_valid", w);
    check("cmd", cmd, v.e_cmd);
    check("reg_address", reg_address, v.e_addr);
    check("reg_data", reg_data, v.e_data);
    check("busy_dispatch", busy, 1'b1);
    check("ack_cleared", uP_ack, 1'b0);
    if (v.reply_en) begin
      tick(1 + delay);
      drive_reply(v.rdata, v.rstatus);
    end
    for (int i = 0; i < 8; i++) begin
      wait_for(0, 1'b1, 1200, "tx_hs2_rise", w);
      if (i == 0 && !v.reply_en) check("timeout_latency", w, 1025);
      check("tx_oe", uP_data_oe, 1'b1);
      check("tx_ack_low", uP_ack, 1'b0);
      check($sformatf("tx_byte%0d", i), uP_data_out, v.e_rd[8*i +: 8]);
      async_uP_handshake_1 = 1'b1;
      wait_for(0, 1'b0, 20, "tx_hs2_fall", w);
      async_uP_handshake_1 = 1'b0;
    end
    wait_for(2, 1'b1, 20, "uP_ack", w);
    check("oe_at_ack", uP_data_oe, 1'b0);
    check("busy_done", busy, 1'b0);
    check("cmd_valid_pulses", cv_count - cv0, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int cv0;
    int w;
    tbl[0] = '{48'h1234_5678_2001, 1'b1, 32'h1234_5678, 32'h0,
               8'h01, 8'h20, 32'h1234_5678, 64'h0000_0000_1234_5678};
    tbl[1] = '{48'h0000_0000_2100, 1'b1, 32'h0000_0064, 32'h0,
               8'h00, 8'h21, 32'h0000_0000, 64'h0000_0000_0000_0064};
    tbl[2] = '{48'hDEAD_BEEF_0500, 1'b0, 32'h0, 32'h0,
               8'h00, 8'h05, 32'hDEAD_BEEF, 64'h8000_0001_0000_0000};

    reset = 1'b1;
    async_uP_start = 1'b0;
    async_uP_handshake_1 = 1'b0;
    async_uP_RW = 1'b0;
    uP_data_in = 8'h00;
    reply_valid = 1'b0;
    reply_data = '0;
    reply_status = '0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_data_out", uP_data_out, 8'h00);
    check("rst_oe", uP_data_oe, 1'b0);
    check("rst_hs2", uP_handshake_2, 1'b0);
    check("rst_ack", uP_ack, 1'b0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Back-to-back table transactions; DONE must hold ack and ignore stray replies.
    for (int k = 0; k < 3; k++) begin
      run_txn(tbl[k], k);
      tick(10);
      check("done_ack_hold", uP_ack, 1'b1);
      drive_reply(32'hA5A5_A5A5, 32'h5A5A_5A5A);
      tick(3);
      check("stray_reply_hs2", uP_handshake_2, 1'b0);
      check("stray_reply_oe", uP_data_oe, 1'b0);
      check("stray_reply_ack", uP_ack, 1'b1);
    end

    // Abort after three written bytes, then a fresh packet.
    cv0 = cv_count;
    pulse_start();
    write_byte(8'h01);
    write_byte(8'h77);
    write_byte(8'h99);
    v = '{48'h0BAD_F00D_3301, 1'b1, 32'hCAFE_0001, 32'h0000_0002,
          8'h01, 8'h33, 32'h0BAD_F00D, 64'h0000_0002_CAFE_0001};
    run_txn(v, 2);
    check("abort_total_pulses", cv_count - cv0, 1);

    // Reset while a reply byte is being presented.
    pulse_start();
    for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i));
    wait_for(1, 1'b1, 20, "cmd_valid_mid", w);
    tick(1);
    drive_reply(32'h1111_2222, 32'h3333_4444);
    wait_for(0, 1'b1, 20, "mid_hs2", w);
    check("mid_oe_before_rst", uP_data_oe, 1'b1);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_hs2", uP_handshake_2, 1'b0);
    check("mid_rst_oe", uP_data_oe, 1'b0);
    check("mid_rst_data", uP_data_out, 8'h00);
    check("mid_rst_ack", uP_ack, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cmd", reg_data, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(3);

    // Randomised transactions against the packet model.
    for (int k = 0; k < 6; k++) begin
      v.wr = {16'($urandom), $urandom};
      v.reply_en = (k != 3);
      v.rdata = $urandom;
      v.rstatus = $urandom;
      v.e_cmd = v.wr[7:0];
      v.e_addr = v.wr[15:8];
      v.e_data = v.wr[47:16];
      v.e_rd = model_rd(v.reply_en, v.rdata, v.rstatus);
      run_txn(v, int'($urandom_range(0, 15)));
      tick(int'($urandom_range(1, 8)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
